// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: turns one local command at a time into a single AXI4-Lite
// write or read and returns the result on a valid/ready response port.
module axi_lite_cmd_master #(
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_ERR_CNT_WIDTH    = 8
) (
    input  logic                              m00_axi_aclk,
    input  logic                              m00_axi_areset,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic                              cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
    output logic                              rsp_valid,
    input  logic                              rsp_ready,
    output logic                              rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                        rsp_resp,
    output logic                              busy,
    output logic [C_ERR_CNT_WIDTH-1:0]        err_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_awaddr,
    output logic [2:0]                        m00_axi_awprot,
    output logic                              m00_axi_awvalid,
    input  logic                              m00_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m00_axi_wstrb,
    output logic                              m00_axi_wvalid,
    input  logic                              m00_axi_wready,
    input  logic [1:0]                        m00_axi_bresp,
    input  logic                              m00_axi_bvalid,
    output logic                              m00_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m00_axi_araddr,
    output logic [2:0]                        m00_axi_arprot,
    output logic                              m00_axi_arvalid,
    input  logic                              m00_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m00_axi_rdata,
    input  logic [1:0]                        m00_axi_rresp,
    input  logic                              m00_axi_rvalid,
    output logic                              m00_axi_rready
);

    localparam int STRB_W = C_M_AXI_DATA_WIDTH / 8;

    // Handshake rule on every channel: a transfer happens on the rising edge where
    // valid and ready are both high; valid never drops before that edge.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t                        state_q;
    logic [C_M_AXI_ADDR_WIDTH-1:0] addr_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]             wstrb_q;
    logic                          write_q;
    logic                          awvalid_q;
    logic                          wvalid_q;
    logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]                    resp_q;
    logic [C_ERR_CNT_WIDTH-1:0]    err_q;

    function automatic logic [C_ERR_CNT_WIDTH-1:0] err_bump(
        input logic [1:0]                 resp,
        input logic [C_ERR_CNT_WIDTH-1:0] cnt
    );
        if (resp != 2'b00 && cnt != {C_ERR_CNT_WIDTH{1'b1}})
            return cnt + C_ERR_CNT_WIDTH'(1);
        return cnt;
    endfunction

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            write_q   <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= 2'b00;
            err_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q  <= cmd_addr;
                        wdata_q <= cmd_wdata;
                        wstrb_q <= cmd_wstrb;
                        write_q <= cmd_write;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            state_q <= RD_ADDR;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W complete independently; leave once neither is still pending.
                    if (awvalid_q && m00_axi_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m00_axi_wready)   wvalid_q  <= 1'b0;
                    if ((!awvalid_q || m00_axi_awready) && (!wvalid_q || m00_axi_wready))
                        state_q <= WR_RESP;
                end
                WR_RESP: begin
                    if (m00_axi_bvalid) begin
                        resp_q  <= m00_axi_bresp;
                        rdata_q <= '0;
                        err_q   <= err_bump(m00_axi_bresp, err_q);
                        state_q <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (m00_axi_arready) state_q <= RD_DATA;
                end
                RD_DATA: begin
                    if (m00_axi_rvalid) begin
                        resp_q  <= m00_axi_rresp;
                        rdata_q <= m00_axi_rdata;
                        err_q   <= err_bump(m00_axi_rresp, err_q);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // All handshake outputs decode from registers only, so no AXI input reaches an AXI output.
    assign cmd_ready       = (state_q == IDLE);
    assign busy            = (state_q != IDLE);
    assign rsp_valid       = (state_q == DONE);
    assign rsp_write       = write_q;
    assign rsp_rdata       = rdata_q;
    assign rsp_resp        = resp_q;
    assign err_count       = err_q;

    assign m00_axi_awaddr  = addr_q;
    assign m00_axi_awprot  = 3'b000;
    assign m00_axi_awvalid = awvalid_q;
    assign m00_axi_wdata   = wdata_q;
    assign m00_axi_wstrb   = wstrb_q;
    assign m00_axi_wvalid  = wvalid_q;
    assign m00_axi_bready  = (state_q == WR_RESP);
    assign m00_axi_araddr  = addr_q;
    assign m00_axi_arprot  = 3'b000;
    assign m00_axi_arvalid = (state_q == RD_ADDR);
    assign m00_axi_rready  = (state_q == RD_DATA);

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master: the bench plays both the command source
// and the AXI4-Lite responder, stepping one clock at a time.
module tb_axi_lite_cmd_master;

    logic        clk;
    logic        areset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [3:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        busy;
    logic [7:0]  err_count;
    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int errors = 0;
    int aw_hs  = 0;
    int w_hs   = 0;

    axi_lite_cmd_master #(
        .C_M_AXI_DATA_WIDTH(32),
        .C_M_AXI_ADDR_WIDTH(4),
        .C_ERR_CNT_WIDTH(8)
    ) dut (
        .m00_axi_aclk(clk),
        .m00_axi_areset(areset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp),
        .busy(busy),
        .err_count(err_count),
        .m00_axi_awaddr(awaddr),
        .m00_axi_awprot(awprot),
        .m00_axi_awvalid(awvalid),
        .m00_axi_awready(awready),
        .m00_axi_wdata(wdata),
        .m00_axi_wstrb(wstrb),
        .m00_axi_wvalid(wvalid),
        .m00_axi_wready(wready),
        .m00_axi_bresp(bresp),
        .m00_axi_bvalid(bvalid),
        .m00_axi_bready(bready),
        .m00_axi_araddr(araddr),
        .m00_axi_arprot(arprot),
        .m00_axi_arvalid(arvalid),
        .m00_axi_arready(arready),
        .m00_axi_rdata(rdata),
        .m00_axi_rresp(rresp),
        .m00_axi_rvalid(rvalid),
        .m00_axi_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshake counters sample pre-edge values in the active region of each rising edge.
    always @(posedge clk) begin
        if (!areset && awvalid && awready) aw_hs <= aw_hs + 1;
        if (!areset && wvalid && wready)   w_hs  <= w_hs + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        int aw0;
        int w0;
        int n;

        areset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 4'h0;
        cmd_wdata = 32'h0;
        cmd_wstrb = 4'h0;
        rsp_ready = 1'b0;
        awready   = 1'b0;
        wready    = 1'b0;
        bresp     = 2'b00;
        bvalid    = 1'b0;
        arready   = 1'b0;
        rdata     = 32'h0;
        rresp     = 2'b00;
        rvalid    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_araddr", araddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wstrb", wstrb, 0);
        check("rst_rsp", {rsp_write, rsp_resp}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_err", err_count, 0);
        check("rst_prot", {awprot, arprot}, 0);
        areset = 1'b0;
        tick();

        // Write 0xC8 to 0x4, responder fully immediate
        aw0 = aw_hs;
        w0  = w_hs;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4;
        cmd_wdata = 32'h0000_00C8; cmd_wstrb = 4'hF;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        tick();
        cmd_valid = 1'b0;
        check("w1_valids", {awvalid, wvalid}, 2'b11);
        check("w1_awaddr", awaddr, 32'h4);
        check("w1_wdata", wdata, 32'hC8);
        check("w1_wstrb", wstrb, 4'hF);
        check("w1_busy", {busy, cmd_ready, bready}, 3'b100);
        tick();
        check("w1_after_hs", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
        tick();
        check("w1_rsp_valid", rsp_valid, 1);
        check("w1_rsp", {rsp_write, rsp_resp}, 3'b100);
        check("w1_rdata", rsp_rdata, 0);
        check("w1_err", err_count, 0);
        check("w1_bready_off", bready, 0);
        check("w1_aw_hs", aw_hs - aw0, 1);
        check("w1_w_hs", w_hs - w0, 1);
        bvalid = 1'b0; awready = 1'b0; wready = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("w1_back_idle", {rsp_valid, busy, cmd_ready}, 3'b001);

        // Write with awready delayed, wready immediate
        aw0 = aw_hs;
        w0  = w_hs;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8;
        cmd_wdata = 32'h1234_5678; cmd_wstrb = 4'h3;
        wready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("w2_c1_valids", {awvalid, wvalid}, 2'b11);
        tick();
        check("w2_c2_valids", {awvalid, wvalid, bready}, 3'b100);
        wready = 1'b0;
        tick();
        check("w2_c3_valids", {awvalid, wvalid, bready}, 3'b100);
        tick();
        check("w2_c4_valids", {awvalid, wvalid, bready}, 3'b100);
        check("w2_c4_awaddr", awaddr, 32'h8);
        awready = 1'b1;
        tick();
        check("w2_both_done", {awvalid, wvalid, bready}, 3'b001);
        awready = 1'b0; bvalid = 1'b1; bresp = 2'b00;
        tick();
        check("w2_rsp_valid", rsp_valid, 1);
        check("w2_aw_hs", aw_hs - aw0, 1);
        check("w2_w_hs", w_hs - w0, 1);
        bvalid = 1'b0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("w2_back_idle", {rsp_valid, cmd_ready}, 2'b01);

        // Read from 0x0, data arrives two cycles after the address handshake
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'h0;
        arready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("r1_arvalid", {arvalid, rready, awvalid, wvalid}, 4'b1000);
        check("r1_araddr", araddr, 0);
        tick();
        arready = 1'b0;
        check("r1_rready", {arvalid, rready}, 2'b01);
        tick();
        check("r1_wait", {rready, rsp_valid}, 2'b10);
        rvalid = 1'b1; rdata = 32'h0000_00A5; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        check("r1_rsp_valid", rsp_valid, 1);
        check("r1_rdata", rsp_rdata, 32'hA5);
        check("r1_rsp", {rsp_write, rsp_resp}, 3'b000);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // cmd_valid held high across a read whose response is stalled
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'hC;
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h5A5A_0001; rresp = 2'b00;
        tick();
        check("h_c1_cmd_ready", cmd_ready, 0);
        check("h_c1_rready", rready, 0);
        tick();
        check("h_c2_cmd_ready", cmd_ready, 0);
        tick();
        rvalid = 1'b0;
        check("h_rsp_valid", rsp_valid, 1);
        check("h_rdata", rsp_rdata, 32'h5A5A_0001);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("h_stall_valid", rsp_valid, 1);
            check("h_stall_rdata", rsp_rdata, 32'h5A5A_0001);
            check("h_stall_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("h_released", {rsp_valid, cmd_ready}, 2'b01);
        tick();
        check("h_second_accept", {busy, arvalid, cmd_ready}, 3'b110);
        cmd_valid = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h0000_0077;
        tick();
        rvalid = 1'b0; arready = 1'b0;
        check("h_second_rdata", rsp_rdata, 32'h77);
        rsp_ready = 1'b1;
        tick();

        // 300 writes, every one answered SLVERR
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h4;
        cmd_wdata = 32'h0000_0010; cmd_wstrb = 4'hF;
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        for (int i = 0; i < 300; i++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!rsp_valid && n < 12);
            check("e_rsp_seen", rsp_valid, 1);
            check("e_err_count", err_count, (i + 1 > 255) ? 255 : i + 1);
            if (i == 0) begin
                check("e_first_rsp", {rsp_write, rsp_resp}, 3'b110);
                check("e_first_rdata", rsp_rdata, 0);
            end
        end
        cmd_valid = 1'b0;
        tick();
        check("e_sat_hold", err_count, 255);
        check("e_idle", busy, 0);

        // Reset while AW is stalled
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8;
        cmd_wdata = 32'hCAFE_0000; cmd_wstrb = 4'hF;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("x_pre_awvalid", awvalid, 1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("x_valids", {awvalid, wvalid, arvalid, bready, rready}, 0);
        check("x_state", {busy, cmd_ready, rsp_valid}, 3'b010);
        check("x_err", err_count, 0);
        check("x_awaddr", awaddr, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("x_no_rsp", {rsp_valid, busy}, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
